// File: rtl/imem_ctrl.sv
//------------------------------------------------------------------------------
// imem_ctrl
//
// Sequencing controller that shares one single-port, byte-wide instruction RAM
// between the fetch stage (32-bit reads) and a program loader (32-bit writes).
// Every 32-bit access is split into four little-endian byte beats.
//
// Optional feature macro: IMEM_CTRL_ALIGN_CHECK_EN
//   defined     : addr[1:0] != 0 is rejected on both ports
//   not defined : unaligned words are legal, only the range check applies
//
// Parameters
//   DEPTH  : RAM size in bytes
//   ADDR_W : RAM address width (DEPTH <= 2**ADDR_W)
//
// Ports
//   clk, reset                      clock, asynchronous active-high reset
//   fetch_req/fetch_pc              fetch request and instruction byte address
//   fetch_ready                     fetch request accepted this cycle (comb.)
//   fetch_valid/instr/fault         one-cycle fetch response
//   ld_req/ld_addr/ld_data          loader write request
//   ld_ready                        loader request accepted this cycle (comb.)
//   ld_ack/ld_err                   one-cycle loader response
//   mem_addr/mem_we/mem_wdata       RAM command (registered)
//   mem_rdata                       RAM read data, one cycle after address
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module imem_ctrl #(
   parameter int DEPTH  = 128,
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic [31:0]       fetch_pc,
   output logic              fetch_ready,
   output logic              fetch_valid,
   output logic [31:0]       fetch_instr,
   output logic              fetch_fault,
   input  logic              ld_req,
   input  logic [31:0]       ld_addr,
   input  logic [31:0]       ld_data,
   output logic              ld_ready,
   output logic              ld_ack,
   output logic              ld_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_RSP
   } state_t;

   localparam logic [31:0] LAST_OK = 32'(DEPTH - 4);
   localparam logic [31:0] NOP     = 32'h0000_0013;

   // Full 32-bit compare so that addresses near 2^32 cannot wrap into range.
   function automatic logic addr_bad(input logic [31:0] a);
      logic bad;
      bad = (a > LAST_OK);
`ifdef IMEM_CTRL_ALIGN_CHECK_EN
      bad = bad | (a[1:0] != 2'b00);
`else
      bad = bad | 1'b0;
`endif
      return bad;
   endfunction

   state_t              r_state;
   logic [2:0]          r_beat;
   logic                r_last_grant;
   logic [ADDR_W-1:0]   r_base;
   logic [31:0]         r_wdata;
   logic [23:0]         r_rbuf;

   logic                r_fetch_valid;
   logic [31:0]         r_fetch_instr;
   logic                r_fetch_fault;
   logic                r_ld_ack;
   logic                r_ld_err;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic                r_mem_we;
   logic [7:0]          r_mem_wdata;

   logic                w_grant_ld;
   logic                w_accept_f;
   logic                w_accept_l;
   logic [2:0]          w_next_beat;
   logic [ADDR_W-1:0]   w_next_addr;

   // Round-robin: the loader wins a tie only if fetch was granted last.
   // Ready is masked during reset so all outputs sit at their reset values.
   assign w_grant_ld  = ld_req && (!fetch_req || !r_last_grant);
   assign w_accept_f  = !reset && (r_state == S_IDLE) && fetch_req && !w_grant_ld;
   assign w_accept_l  = !reset && (r_state == S_IDLE) && w_grant_ld;
   assign w_next_beat = r_beat + 3'd1;
   assign w_next_addr = r_base + ADDR_W'(w_next_beat);

   assign fetch_ready = w_accept_f;
   assign ld_ready    = w_accept_l;
   assign fetch_valid = r_fetch_valid;
   assign fetch_instr = r_fetch_instr;
   assign fetch_fault = r_fetch_fault;
   assign ld_ack      = r_ld_ack;
   assign ld_err      = r_ld_err;
   assign mem_addr    = r_mem_addr;
   assign mem_we      = r_mem_we;
   assign mem_wdata   = r_mem_wdata;

   // Control FSM with registered outputs. The first beat address is driven
   // straight from the request on the accept edge so the RAM sees it at E0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_beat        <= 3'd0;
         r_last_grant  <= 1'b0;
         r_fetch_valid <= 1'b0;
         r_fetch_instr <= 32'h0;
         r_fetch_fault <= 1'b0;
         r_ld_ack      <= 1'b0;
         r_ld_err      <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_we      <= 1'b0;
         r_mem_wdata   <= 8'h0;
      end else begin
         r_fetch_valid <= 1'b0;
         r_ld_ack      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept_f) begin
                  r_last_grant <= 1'b0;
                  if (addr_bad(fetch_pc)) begin
                     r_state       <= S_RSP;
                     r_fetch_valid <= 1'b1;
                     r_fetch_fault <= 1'b1;
                     r_fetch_instr <= NOP;
                  end else begin
                     r_state    <= S_RD;
                     r_beat     <= 3'd0;
                     r_mem_addr <= fetch_pc[ADDR_W-1:0];
                  end
               end else if (w_accept_l) begin
                  r_last_grant <= 1'b1;
                  if (addr_bad(ld_addr)) begin
                     r_state  <= S_RSP;
                     r_ld_ack <= 1'b1;
                     r_ld_err <= 1'b1;
                  end else begin
                     r_state     <= S_WR;
                     r_beat      <= 3'd0;
                     r_mem_we    <= 1'b1;
                     r_mem_addr  <= ld_addr[ADDR_W-1:0];
                     r_mem_wdata <= ld_data[7:0];
                  end
               end
            end
            S_RD: begin
               r_beat <= w_next_beat;
               if (r_beat < 3'd3) begin
                  r_mem_addr <= w_next_addr;
               end
               // Beat 4 only drains byte 3 from the RAM output register.
               if (r_beat == 3'd4) begin
                  r_state       <= S_RSP;
                  r_fetch_valid <= 1'b1;
                  r_fetch_fault <= 1'b0;
                  r_fetch_instr <= {mem_rdata, r_rbuf};
               end
            end
            S_WR: begin
               if (r_beat == 3'd3) begin
                  r_state     <= S_RSP;
                  r_mem_we    <= 1'b0;
                  r_mem_wdata <= 8'h0;
                  r_ld_ack    <= 1'b1;
                  r_ld_err    <= 1'b0;
               end else begin
                  r_beat      <= w_next_beat;
                  r_mem_addr  <= w_next_addr;
                  r_mem_wdata <= r_wdata[{w_next_beat[1:0], 3'b000} +: 8];
               end
            end
            S_RSP: begin
               r_state       <= S_IDLE;
               r_fetch_fault <= 1'b0;
               r_ld_err      <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Request capture and read assembly; pure datapath, no reset needed.
   // Bytes 0..2 are shifted in on beats 1..3, byte 3 is taken on beat 4.
   always_ff @(posedge clk) begin
      if (w_accept_f) begin
         r_base <= fetch_pc[ADDR_W-1:0];
      end else if (w_accept_l) begin
         r_base  <= ld_addr[ADDR_W-1:0];
         r_wdata <= ld_data;
      end
      if (r_state == S_RD && r_beat != 3'd0) begin
         r_rbuf <= {mem_rdata, r_rbuf[23:8]};
      end
   end

endmodule

// File: tb/tb_imem_ctrl.sv
//------------------------------------------------------------------------------
// tb_imem_ctrl
//
// Directed bench for imem_ctrl with a behavioural 128-byte synchronous RAM.
// Honours IMEM_CTRL_ALIGN_CHECK_EN for the unaligned fetch case.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_imem_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fetch_req = 1'b0;
   logic [31:0] fetch_pc = 32'h0;
   logic        fetch_ready;
   logic        fetch_valid;
   logic [31:0] fetch_instr;
   logic        fetch_fault;
   logic        ld_req = 1'b0;
   logic [31:0] ld_addr = 32'h0;
   logic [31:0] ld_data = 32'h0;
   logic        ld_ready;
   logic        ld_ack;
   logic        ld_err;
   logic [6:0]  mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = 8'h0;

   logic [7:0]  ram [0:127];

   int checks = 0;
   int fails  = 0;
   int both_hi = 0;
   int we_cnt  = 0;
   int ack_cnt = 0;

   imem_ctrl #(.DEPTH(128), .ADDR_W(7)) dut (
      .clk         (clk),
      .reset       (reset),
      .fetch_req   (fetch_req),
      .fetch_pc    (fetch_pc),
      .fetch_ready (fetch_ready),
      .fetch_valid (fetch_valid),
      .fetch_instr (fetch_instr),
      .fetch_fault (fetch_fault),
      .ld_req      (ld_req),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .ld_ready    (ld_ready),
      .ld_ack      (ld_ack),
      .ld_err      (ld_err),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous single-port RAM: read data appears one cycle after address.
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   always @(negedge clk) begin
      if (fetch_ready && ld_ready) both_hi++;
      if (mem_we) we_cnt++;
      if (ld_ack) ack_cnt++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_flags"},
          {25'h0, fetch_ready, fetch_valid, fetch_fault, ld_ready, ld_ack, ld_err, mem_we},
          32'h0);
      chk({tag, "_instr"}, fetch_instr, 32'h0);
      chk({tag, "_maddr"}, {25'h0, mem_addr}, 32'h0);
      chk({tag, "_wdata"}, {24'h0, mem_wdata}, 32'h0);
   endtask

   // Issue one request, wait (bounded) for its grant, then count edges from
   // the grant cycle to the response pulse.
   task automatic run_txn(input bit is_ld, input logic [31:0] addr, input logic [31:0] data,
                          output logic [31:0] lat, output logic [31:0] instr, output logic flag);
      int  n;
      logic got;
      logic resp;
      if (is_ld) begin
         ld_addr = addr; ld_data = data; ld_req = 1'b1;
      end else begin
         fetch_pc = addr; fetch_req = 1'b1;
      end
      #1;
      n = 0;
      got = is_ld ? ld_ready : fetch_ready;
      while (!got && n < 20) begin
         tick; n++;
         got = is_ld ? ld_ready : fetch_ready;
      end
      chk(is_ld ? "ld_grant" : "fetch_grant", {31'h0, got}, 32'h1);
      lat = 0;
      resp = 1'b0;
      while (!resp && lat < 30) begin
         tick; lat++;
         resp = is_ld ? ld_ack : fetch_valid;
      end
      instr = fetch_instr;
      flag  = is_ld ? ld_err : fetch_fault;
      ld_req = 1'b0;
      fetch_req = 1'b0;
   endtask

   logic [31:0] lat;
   logic [31:0] instr;
   logic        flag;
   logic [3:0]  exp_ld;
   logic        g;
   logic        resp;
   int          n;
   int          snap_we;
   int          snap_ack;
   logic [6:0]  snap_addr;

   initial begin
      // Reset with both requests pending: ready must stay low during reset.
      fetch_pc = 32'h0; ld_addr = 32'h8; ld_data = 32'hDDCC_BBAA;
      fetch_req = 1'b1; ld_req = 1'b1;
      tick; tick;
      chk_reset_outs("reset");

      // Release with both high: loader first, then strict alternation.
      reset = 1'b0;
      #1;
      exp_ld = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (!(fetch_ready || ld_ready) && n < 20) begin tick; n++; end
         g = ld_ready;
         chk("arb_grant_is_ld", {31'h0, g}, {31'h0, exp_ld[i]});
         lat = 0; resp = 1'b0;
         while (!resp && lat < 30) begin
            tick; lat++;
            resp = g ? ld_ack : fetch_valid;
         end
         chk("arb_resp_seen", {31'h0, resp}, 32'h1);
      end
      fetch_req = 1'b0; ld_req = 1'b0;
      tick;
      chk("arb_ready_both_high", both_hi, 0);

      // Load then fetch the same word.
      run_txn(1'b1, 32'h0, 32'h0094_0333, lat, instr, flag);
      chk("ld0_latency", lat, 32'd5);
      chk("ld0_err", {31'h0, flag}, 32'h0);
      chk("ld0_ram", {ram[3], ram[2], ram[1], ram[0]}, 32'h0094_0333);
      tick;
      run_txn(1'b1, 32'h4, 32'h8765_4321, lat, instr, flag);
      chk("ld4_latency", lat, 32'd5);
      chk("ld4_ram", {ram[7], ram[6], ram[5], ram[4]}, 32'h8765_4321);
      tick;
      run_txn(1'b0, 32'h0, 32'h0, lat, instr, flag);
      chk("f0_latency", lat, 32'd6);
      chk("f0_instr", instr, 32'h0094_0333);
      chk("f0_fault", {31'h0, flag}, 32'h0);
      tick;

      // Unaligned fetch.
      run_txn(1'b0, 32'h2, 32'h0, lat, instr, flag);
`ifdef IMEM_CTRL_ALIGN_CHECK_EN
      chk("f2_latency", lat, 32'd1);
      chk("f2_instr", instr, 32'h0000_0013);
      chk("f2_fault", {31'h0, flag}, 32'h1);
`else
      chk("f2_latency", lat, 32'd6);
      chk("f2_instr", instr, 32'h4321_0094);
      chk("f2_fault", {31'h0, flag}, 32'h0);
`endif
      tick;

      // Out-of-range fetch: immediate fault, RAM port untouched.
      snap_addr = mem_addr; snap_we = we_cnt;
      run_txn(1'b0, 32'd125, 32'h0, lat, instr, flag);
      chk("f125_latency", lat, 32'd1);
      chk("f125_instr", instr, 32'h0000_0013);
      chk("f125_fault", {31'h0, flag}, 32'h1);
      chk("f125_maddr", {25'h0, mem_addr}, {25'h0, snap_addr});
      chk("f125_we", we_cnt - snap_we, 0);
      tick;

      // Load near 2^32 must not wrap into range.
      snap_we = we_cnt;
      run_txn(1'b1, 32'hFFFF_FFFC, 32'h1234_5678, lat, instr, flag);
      chk("ldwrap_latency", lat, 32'd1);
      chk("ldwrap_err", {31'h0, flag}, 32'h1);
      tick; tick;
      chk("ldwrap_we", we_cnt - snap_we, 0);

      // Reset in the middle of a load to byte 8 (holds DDCCBBAA).
      ld_addr = 32'h8; ld_data = 32'h4433_2211; ld_req = 1'b1;
      #1;
      n = 0;
      while (!ld_ready && n < 20) begin tick; n++; end
      chk("midrst_grant", {31'h0, ld_ready}, 32'h1);
      tick; tick; tick;
      chk("midrst_beat2", {24'h0, mem_we, mem_addr}, {24'h0, 1'b1, 7'd10});
      snap_ack = ack_cnt;
      reset = 1'b1;
      #1;
      chk_reset_outs("midrst");
      ld_req = 1'b0;
      tick; tick;
      reset = 1'b0;
      for (int i = 0; i < 8; i++) tick;
      chk("midrst_no_ack", ack_cnt - snap_ack, 0);
      chk("midrst_ram", {ram[11], ram[10], ram[9], ram[8]}, 32'hDDCC_2211);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
